// File: rtl/screen_display_ctrl.sv
// Display-side controller for the screen timer: tear-free mode commits at frame starts, scoring and best score.
// Optional SNITCH_BONUS_EN macro adds a once-per-trace-screen snitch bonus.
module screen_display_ctrl #(
    parameter int SCORE_W    = 8,
    parameter int SNITCH_PTS = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         curr_screen,
    input  logic [5:0]         total_screens,
    input  logic               end_of_game,
    input  logic               play_again,
    input  logic               frame_start,
    input  logic               hit,
    input  logic               snitch,
    output logic [2:0]         disp_mode,
    output logic [3:0]         trace_index,
    output logic               screen_ack,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best_score,
    output logic               restart_req
);

    typedef enum logic [2:0] {
        MODE_TITLE   = 3'd0,
        MODE_TRACE   = 3'd1,
        MODE_MESSAGE = 3'd2,
        MODE_SCORE   = 3'd3,
        MODE_BLANK   = 3'd4
    } mode_t;

    localparam logic [SCORE_W+1:0] SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};

    mode_t              state_reg, state_next, target;
    logic [4:0]         prev_screen_reg;
    logic               prev_eog_reg;
    logic               prev_play_reg;
    logic               pending_reg, pending_next;
    logic               ack_reg;
    logic               restart_reg;
    logic [3:0]         trace_idx_reg, trace_idx_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [SCORE_W-1:0] best_reg, best_next;
    logic [SCORE_W+1:0] inc, sum;
    logic               change_now, play_rise, commit;

    always_comb begin
        target = MODE_BLANK;
        if (end_of_game)
            target = MODE_SCORE;
        else if (curr_screen == 5'd1)
            target = MODE_TITLE;
        else if ((curr_screen != 5'd0) && ({1'b0, curr_screen} < total_screens))
            target = curr_screen[0] ? MODE_MESSAGE : MODE_TRACE;
    end

    // A change landing in the same cycle as frame_start must still commit on that frame.
    assign change_now = (curr_screen != prev_screen_reg) || (end_of_game != prev_eog_reg);
    assign play_rise  = play_again && !prev_play_reg;
    assign commit     = frame_start && (pending_reg || change_now || (target != state_reg));

`ifdef SNITCH_BONUS_EN
    logic snitch_used_reg, snitch_used_next, snitch_hit;

    assign snitch_hit = snitch && (state_reg == MODE_TRACE) && !snitch_used_reg;

    always_comb begin
        snitch_used_next = snitch_used_reg || snitch_hit;
        if (commit && (target == MODE_TRACE))
            snitch_used_next = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            snitch_used_reg <= 1'b0;
        else
            snitch_used_reg <= snitch_used_next;
    end
`else
    logic unused_snitch;
    assign unused_snitch = snitch;
`endif

    always_comb begin
        inc = '0;
        if (hit && (state_reg == MODE_TRACE))
            inc = (SCORE_W+2)'(1);
`ifdef SNITCH_BONUS_EN
        if (snitch_hit)
            inc = inc + (SCORE_W+2)'(SNITCH_PTS);
`endif
        sum = {2'b00, score_reg} + inc;

        // Restart wins over any scoring event in the same cycle.
        if (play_rise)
            score_next = '0;
        else if (sum > SCORE_MAX)
            score_next = '1;
        else
            score_next = sum[SCORE_W-1:0];

        state_next     = state_reg;
        trace_idx_next = trace_idx_reg;
        best_next      = best_reg;
        pending_next   = (pending_reg || change_now) && !commit;
        if (play_rise)
            pending_next = 1'b1;

        if (commit) begin
            state_next = target;
            if (target == MODE_TRACE)
                trace_idx_next = curr_screen[4:1];
            if ((target == MODE_SCORE) && (score_next > best_reg))
                best_next = score_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= MODE_BLANK;
            prev_screen_reg <= '0;
            prev_eog_reg    <= 1'b0;
            prev_play_reg   <= 1'b0;
            pending_reg     <= 1'b0;
            ack_reg         <= 1'b0;
            restart_reg     <= 1'b0;
            trace_idx_reg   <= '0;
            score_reg       <= '0;
            best_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            prev_screen_reg <= curr_screen;
            prev_eog_reg    <= end_of_game;
            prev_play_reg   <= play_again;
            pending_reg     <= pending_next;
            ack_reg         <= commit;
            restart_reg     <= play_rise;
            trace_idx_reg   <= trace_idx_next;
            score_reg       <= score_next;
            best_reg        <= best_next;
        end
    end

    assign disp_mode   = state_reg;
    assign trace_index = trace_idx_reg;
    assign screen_ack  = ack_reg;
    assign score       = score_reg;
    assign best_score  = best_reg;
    assign restart_req = restart_reg;

endmodule
